ct_mem_arbiter: RTL and testbench

//  Shares the single read port of the ciphertext output buffer between two requesters:
//  req0 = host AXI readout, req1 = FO re-encryption compare engine.

---
 rtl/kyber_ct_pkg.sv | 15 +
 rtl/rd_tag_pipe.sv | 37 +++
 rtl/ct_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_ct_mem_arbiter.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kyber_ct_pkg.sv
// Shared types for the Kyber ciphertext buffer readout path.
// Arbiter states and requester ids.
package kyber_ct_pkg;

  typedef enum logic [1:0] {
    WAIT_RDY = 2'd0,
    SERVE    = 2'd1,
    DRAIN    = 2'd2,
    LOAD     = 2'd3
  } arb_state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_CMP  = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read tag pipeline: tracks {valid,id} of issued reads
// until the fixed-latency memory returns their data.
module rd_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [ID_W-1:0] in_id,
  output logic            out_valid,
  output logic [ID_W-1:0] out_id,
  output logic            empty
);

  logic [DEPTH-1:0] vld;
  logic [ID_W-1:0]  ids [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) ids[i] <= '0;
    end else begin
      vld[0] <= in_valid;
      ids[0] <= in_id;
      for (int i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        ids[i] <= ids[i-1];
      end
    end
  end

  assign out_valid = vld[DEPTH-1];
  assign out_id    = ids[DEPTH-1];
  assign empty     = ~|vld;

endmodule

// File: rtl/ct_mem_arbiter.sv
// Round-robin arbiter for the ciphertext buffer read port,
// plus reload sequencing towards the splitter.
module ct_mem_arbiter
  import kyber_ct_pkg::*;
#(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int RD_LATENCY      = 2,
  parameter int LOAD_MIN_CYCLES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_resetn,
  input  logic                  i_load,
  output logic                  o_chomp,
  input  logic                  i_mem_ready,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_req0,
  input  logic [ADDR_WIDTH-1:0] i_addr0,
  output logic                  o_gnt0,
  output logic                  o_rvalid0,
  output logic [DATA_WIDTH-1:0] o_rdata0,
  input  logic                  i_req1,
  input  logic [ADDR_WIDTH-1:0] i_addr1,
  output logic                  o_gnt1,
  output logic                  o_rvalid1,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(LOAD_MIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(LOAD_MIN_CYCLES - 1);

  arb_state_t            state, state_n;
  logic                  rr_ptr;
  logic                  load_pend;
  logic                  load_entry;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  grant_en;
  logic                  any_gnt;
  logic                  enter_load;
  logic                  cnt_done;
  logic                  pipe_valid;
  logic [0:0]            pipe_id;
  logic                  pipe_empty;

  assign grant_en = (state == SERVE) && i_mem_ready && !load_pend;
  assign o_gnt0 = grant_en && i_req0 && (!i_req1 || rr_ptr == REQ_HOST);
  assign o_gnt1 = grant_en && i_req1 && (!i_req0 || rr_ptr == REQ_CMP);
  assign any_gnt = o_gnt0 | o_gnt1;

  assign o_mem_addr = o_gnt1 ? i_addr1 :
                      o_gnt0 ? i_addr0 : addr_q;

  assign cnt_done   = (cnt >= CNT_DONE);
  assign enter_load = (state != LOAD) && (state_n == LOAD);

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_RDY: begin
        if (load_pend && pipe_empty) state_n = LOAD;
        else if (i_mem_ready)        state_n = SERVE;
      end
      SERVE: begin
        if (load_pend)         state_n = DRAIN;
        else if (!i_mem_ready) state_n = WAIT_RDY;
      end
      DRAIN: begin
        if (pipe_empty) state_n = LOAD;
      end
      LOAD: begin
        if (cnt_done && i_mem_ready) state_n = WAIT_RDY;
      end
      default: state_n = WAIT_RDY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state      <= WAIT_RDY;
      rr_ptr     <= REQ_HOST;
      load_pend  <= 1'b0;
      load_entry <= 1'b0;
      cnt        <= '0;
      addr_q     <= '0;
    end else begin
      state      <= state_n;
      load_entry <= enter_load;
      // a reload request arriving on the entry cycle stays pending
      load_pend  <= enter_load ? i_load : (load_pend | i_load);
      if (enter_load)
        cnt <= '0;
      else if (state == LOAD && !cnt_done)
        cnt <= cnt + 1'b1;
      if (any_gnt) begin
        rr_ptr <= ~o_gnt1;
        addr_q <= o_mem_addr;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (RD_LATENCY),
    .ID_W  (1)
  ) u_tag_pipe (
    .clk       (i_clk),
    .rst_n     (i_resetn),
    .in_valid  (any_gnt),
    .in_id     (o_gnt1),
    .out_valid (pipe_valid),
    .out_id    (pipe_id),
    .empty     (pipe_empty)
  );

  assign o_chomp   = load_entry;
  assign o_rvalid0 = pipe_valid && (pipe_id == REQ_HOST);
  assign o_rvalid1 = pipe_valid && (pipe_id == REQ_CMP);
  assign o_rdata0  = o_rvalid0 ? i_mem_rdata : '0;
  assign o_rdata1  = o_rvalid1 ? i_mem_rdata : '0;
  assign o_busy    = (state != SERVE) || !pipe_empty;

endmodule

// File: tb/tb_ct_mem_arbiter.sv
// Directed bench for ct_mem_arbiter with a 2-cycle
// latency buffer model; mem[a] = 0xC0DE0000 + 3*a.
module tb_ct_mem_arbiter;
  import kyber_ct_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic        chomp;
  logic        ready = 1'b0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  a1 = '0, a2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a1 <= mem_addr;
    a2 <= a1;
  end
  assign mem_rdata = 32'hC0DE_0000 + 32'(a2) * 32'd3;

  ct_mem_arbiter dut (
    .i_clk       (clk),
    .i_resetn    (rst_n),
    .i_load      (load),
    .o_chomp     (chomp),
    .i_mem_ready (ready),
    .o_mem_addr  (mem_addr),
    .i_mem_rdata (mem_rdata),
    .i_req0      (req0),
    .i_addr0     (addr0),
    .o_gnt0      (gnt0),
    .o_rvalid0   (rvalid0),
    .o_rdata0    (rdata0),
    .i_req1      (req1),
    .i_addr1     (addr1),
    .o_gnt1      (gnt1),
    .o_rvalid1   (rvalid1),
    .o_rdata1    (rdata1),
    .o_busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // leaves the bench at posedge+1 of the first post-reset cycle
  task automatic do_reset(input logic rdy);
    tick();
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; load = 1'b0; ready = rdy;
    @(negedge clk);
    check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    check("rst_chomp", 32'(chomp), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    tick();
    rst_n = 1'b1;
  endtask

  logic [9:0] e_g0, e_g1, e_rv0, e_rv1, e_ch;

  initial begin
    // 1: single host read, latency 2
    do_reset(1'b1);
    req0 = 1'b1; addr0 = 8'd5;
    @(negedge clk);
    check("t1_wait_nogrant", 32'(gnt0), 32'd0);
    tick();
    @(negedge clk);
    check("t1_gnt0", 32'(gnt0), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'd5);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    check("t1_rv0_early", 32'(rvalid0), 32'd0);
    tick();
    @(negedge clk);
    check("t1_rv0", 32'(rvalid0), 32'd1);
    check("t1_rdata0", rdata0, 32'hC0DE_000F);
    check("t1_rv1", 32'(rvalid1), 32'd0);
    tick();
    @(negedge clk);
    check("t1_rv0_done", 32'(rvalid0), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);

    // 2: both requesters, alternating grants, no gaps
    do_reset(1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      req0 = (k < 4); req1 = (k < 4);
      addr0 = 8'd1; addr1 = 8'd2;
      @(negedge clk);
      check($sformatf("t2_g0_%0d", k), 32'(gnt0),
            32'(k < 4 && k % 2 == 0));
      check($sformatf("t2_g1_%0d", k), 32'(gnt1),
            32'(k < 4 && k % 2 == 1));
      check($sformatf("t2_rv0_%0d", k), 32'(rvalid0),
            32'(k >= 2 && k % 2 == 0));
      check($sformatf("t2_rv1_%0d", k), 32'(rvalid1),
            32'(k >= 2 && k % 2 == 1));
      if (k >= 2 && k % 2 == 0)
        check($sformatf("t2_d0_%0d", k), rdata0, 32'hC0DE_0003);
      if (k >= 2 && k % 2 == 1)
        check($sformatf("t2_d1_%0d", k), rdata1, 32'hC0DE_0006);
    end
    req0 = 1'b0; req1 = 1'b0;

    // 3: reload request during back-to-back reads
    e_g0  = 10'b10_0000_0001;
    e_g1  = 10'b00_0000_0010;
    e_rv0 = 10'b00_0000_0100;
    e_rv1 = 10'b00_0000_1000;
    e_ch  = 10'b00_0010_0000;
    do_reset(1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      if (k > 0) tick();
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 8'd1; addr1 = 8'd2;
      load = (k == 1);
      ready = !(k == 5 || k == 6);
      @(negedge clk);
      check($sformatf("t3_g0_%0d", k), 32'(gnt0), 32'(e_g0[k]));
      check($sformatf("t3_g1_%0d", k), 32'(gnt1), 32'(e_g1[k]));
      check($sformatf("t3_rv0_%0d", k), 32'(rvalid0), 32'(e_rv0[k]));
      check($sformatf("t3_rv1_%0d", k), 32'(rvalid1), 32'(e_rv1[k]));
      check($sformatf("t3_chomp_%0d", k), 32'(chomp), 32'(e_ch[k]));
      if (k == 2) check("t3_d0", rdata0, 32'hC0DE_0003);
      if (k == 3) check("t3_d1", rdata1, 32'hC0DE_0006);
      if (k == 7) check("t3_busy", 32'(busy), 32'd1);
    end
    req0 = 1'b0; req1 = 1'b0; load = 1'b0;

    // 4: not ready from reset, grant one cycle after ready rises
    do_reset(1'b0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      req0 = 1'b1; req1 = 1'b1;
      addr0 = 8'd7; addr1 = 8'd9;
      ready = (k >= 3);
      @(negedge clk);
      check($sformatf("t4_g0_%0d", k), 32'(gnt0), 32'(k == 4));
      check($sformatf("t4_g1_%0d", k), 32'(gnt1), 32'd0);
    end
    check("t4_addr", 32'(mem_addr), 32'd7);
    req0 = 1'b0; req1 = 1'b0;

    // 5: ready drops with two reads in flight
    do_reset(1'b1);
    tick();
    req0 = 1'b1; addr0 = 8'd3;
    @(negedge clk);
    check("t5_g0", 32'(gnt0), 32'd1);
    tick();
    req0 = 1'b0; req1 = 1'b1; addr1 = 8'd4;
    @(negedge clk);
    check("t5_g1", 32'(gnt1), 32'd1);
    tick();
    req1 = 1'b0; ready = 1'b0;
    @(negedge clk);
    check("t5_rv0", 32'(rvalid0), 32'd1);
    check("t5_d0", rdata0, 32'hC0DE_0009);
    tick();
    @(negedge clk);
    check("t5_rv1", 32'(rvalid1), 32'd1);
    check("t5_d1", rdata1, 32'hC0DE_000C);
    check("t5_state", 32'(dut.state), 32'(WAIT_RDY));
    tick();
    @(negedge clk);
    check("t5_quiet", 32'({rvalid0, rvalid1}), 32'd0);
    check("t5_busy", 32'(busy), 32'd1);

    // 6: async reset with a read in flight
    do_reset(1'b1);
    tick();
    req0 = 1'b1; addr0 = 8'd6;
    @(negedge clk);
    check("t6_g0", 32'(gnt0), 32'd1);
    tick();
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_rst_rv", 32'({rvalid0, rvalid1}), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    check("t6_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
    check("t6_rst_chomp", 32'(chomp), 32'd0);
    check("t6_rr_ptr", 32'(dut.rr_ptr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_no_rv_%0d", k), 32'(rvalid0), 32'd0);
      check($sformatf("t6_no_d_%0d", k), rdata0, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
